// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and saturation helper for the quadrant
// sin/cos CORDIC rotator.
package cordic_pkg;

  localparam int unsigned ATAN_N = 14;

  // atan(2^-i) in binary-angle units (full turn = 65536)
  localparam logic signed [15:0] ATAN_TABLE [0:ATAN_N-1] = '{
    16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326, 16'sd163,
    16'sd81,   16'sd41,   16'sd20,   16'sd10,   16'sd5,   16'sd3,   16'sd1
  };

  localparam int K_INIT = 9949;
  localparam int Q_ONE  = 16384;

  typedef enum logic [1:0] {IDLE, ROT, FIN} state_e;

  function automatic logic signed [15:0] sat_q214(input logic signed [31:0] v);
    logic signed [15:0] r;
    if (v > Q_ONE)       r = 16'sd16384;
    else if (v < -Q_ONE) r = -16'sd16384;
    else                 r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/cordic_iter_step.sv
// One combinational CORDIC micro-rotation in rotation mode.
module cordic_iter_step #(
  parameter int unsigned IW = 18,
  parameter int unsigned ZW = 16
) (
  input  logic signed [IW-1:0] x_i,
  input  logic signed [IW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [3:0]    shift,
  input  logic signed [ZW-1:0] atan_i,
  output logic signed [IW-1:0] x_o,
  output logic signed [IW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;

  always_comb begin
    xs = x_i >>> shift;
    ys = y_i >>> shift;
    if (!z_i[ZW-1]) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_quadrant_sincos.sv
// Iterative CORDIC producing cos/sin of the first-quadrant residual plus the
// quadrant code, forming the four candidates and select of a cosine mux.
module cordic_quadrant_sincos
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 14,
  parameter int unsigned DW   = 16,
  parameter int unsigned IW   = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   phase,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] c_pos,
  output logic [DW-1:0] s_neg,
  output logic [DW-1:0] c_neg,
  output logic [DW-1:0] s_pos,
  output logic [1:0]    quad
);

  state_e               state_q, state_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, x_n, y_n;
  logic signed [15:0]   z_q, z_d, z_n;
  logic        [3:0]    i_q, i_d;
  logic        [1:0]    quad_lat_q, quad_lat_d, quad_q, quad_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic signed [15:0]   c_pos_q, c_pos_d, c_neg_q, c_neg_d;
  logic signed [15:0]   s_pos_q, s_pos_d, s_neg_q, s_neg_d;
  logic signed [15:0]   x_sat, y_sat;

  cordic_iter_step #(.IW(IW), .ZW(16)) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .shift  (i_q),
    .atan_i (ATAN_TABLE[i_q]),
    .x_o    (x_n),
    .y_o    (y_n),
    .z_o    (z_n)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    i_d        = i_q;
    quad_lat_d = quad_lat_q;
    quad_d     = quad_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    c_pos_d    = c_pos_q;
    c_neg_d    = c_neg_q;
    s_pos_d    = s_pos_q;
    s_neg_d    = s_neg_q;
    x_sat      = sat_q214(32'(x_q));
    y_sat      = sat_q214(32'(y_q));
    case (state_q)
      IDLE: begin
        if (start) begin
          quad_lat_d = phase[15:14];
          z_d        = {2'b00, phase[13:0]};
          x_d        = IW'(K_INIT);
          y_d        = '0;
          i_d        = '0;
          busy_d     = 1'b1;
          state_d    = ROT;
        end
      end
      ROT: begin
        x_d = x_n;
        y_d = y_n;
        z_d = z_n;
        i_d = i_q + 4'd1;
        if (i_q == 4'(ITER - 1)) state_d = FIN;
      end
      FIN: begin
        // quad is published together with the data so the mux select and
        // candidates always belong to the same request
        c_pos_d = x_sat;
        c_neg_d = -x_sat;
        s_pos_d = y_sat;
        s_neg_d = -y_sat;
        quad_d  = quad_lat_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      i_q        <= '0;
      quad_lat_q <= '0;
      quad_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      c_pos_q    <= '0;
      c_neg_q    <= '0;
      s_pos_q    <= '0;
      s_neg_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      i_q        <= i_d;
      quad_lat_q <= quad_lat_d;
      quad_q     <= quad_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      c_pos_q    <= c_pos_d;
      c_neg_q    <= c_neg_d;
      s_pos_q    <= s_pos_d;
      s_neg_q    <= s_neg_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign c_pos = c_pos_q;
  assign c_neg = c_neg_q;
  assign s_pos = s_pos_q;
  assign s_neg = s_neg_q;
  assign quad  = quad_q;

endmodule

// File: tb/tb_cordic_quadrant_sincos.sv
// Scoreboard bench for cordic_quadrant_sincos: directed phases with
// hand-computed cos/sin, latency, ignored-start, done-cycle start and reset abort.
module tb_cordic_quadrant_sincos;

  localparam int ITER = 14;
  localparam int LAT  = ITER + 1;
  localparam int TOL  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] phase = '0;
  logic        busy, done;
  logic [15:0] c_pos, s_neg, c_neg, s_pos;
  logic [1:0]  quad;

  typedef struct {
    logic [15:0] ph;
    logic [1:0]  q;
    int          c;
    int          s;
    int          m;
  } vec_t;

  vec_t vecs[6];
  vec_t exp_q[$];
  vec_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   prev_done = 1'b0;

  cordic_quadrant_sincos #(.ITER(ITER), .DW(16), .IW(18)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .phase (phase),
    .busy  (busy),
    .done  (done),
    .c_pos (c_pos),
    .s_neg (s_neg),
    .c_neg (c_neg),
    .s_pos (s_pos),
    .quad  (quad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int diff;
    n_cmp++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic int mux_out(input logic [1:0] s);
    case (s)
      2'd0:    return int'($signed(c_pos));
      2'd1:    return int'($signed(s_neg));
      2'd2:    return int'($signed(c_neg));
      default: return int'($signed(s_pos));
    endcase
  endfunction

  // Monitor: every done pulse consumes one expectation
  always @(negedge clk) begin
    if (done) begin
      chk("done_width", int'(prev_done), 0, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with empty scoreboard want none");
      end else begin
        e = exp_q.pop_front();
        chk("quad",  int'(quad), int'(e.q), 0);
        chk("c_pos", int'($signed(c_pos)), e.c, TOL);
        chk("s_pos", int'($signed(s_pos)), e.s, TOL);
        chk("c_neg", int'($signed(c_neg)), -e.c, TOL);
        chk("s_neg", int'($signed(s_neg)), -e.s, TOL);
        chk("mux_cos", mux_out(quad), e.m, TOL);
      end
    end
    prev_done = done;
  end

  task automatic wait_done(input string name, input int exp_cyc);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 4 * LAT);
    chk(name, cyc, exp_cyc, 0);
  endtask

  // Called at a negedge with the DUT idle
  task automatic issue(input int k);
    start = 1'b1;
    phase = vecs[k].ph;
    exp_q.push_back(vecs[k]);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1, 0);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 2'd0, 16384, 0,     16384};
    vecs[1] = '{16'h2000, 2'd0, 11585, 11585, 11585};
    vecs[2] = '{16'h4000, 2'd1, 16384, 0,     0};
    vecs[3] = '{16'hAAAB, 2'd2, 8192,  14189, -8192};
    vecs[4] = '{16'hC000, 2'd3, 16384, 0,     0};
    vecs[5] = '{16'h1555, 2'd0, 14189, 8192,  14189};

    repeat (3) @(negedge clk);
    chk("rst_busy",  int'(busy),  0, 0);
    chk("rst_done",  int'(done),  0, 0);
    chk("rst_c_pos", int'(c_pos), 0, 0);
    chk("rst_quad",  int'(quad),  0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic phases, each with a latency check
    foreach (vecs[k]) begin
      if (k != 2) begin
        issue(k);
        wait_done("latency", LAT);
        @(negedge clk);
      end
    end

    // Start during busy is ignored; start held through the done cycle is taken
    issue(2);
    repeat (4) @(negedge clk);
    start = 1'b1;
    phase = vecs[1].ph;
    wait_done("latency_ignored_start", LAT - 4);
    exp_q.push_back(vecs[1]);
    @(negedge clk);
    start = 1'b0;
    chk("busy_done_cycle_start", int'(busy), 1, 0);
    wait_done("latency_back_to_back", LAT);
    @(negedge clk);

    // Leave quad=3 on the outputs so the reset clear is observable
    issue(4);
    wait_done("latency_pre_reset", LAT);
    @(negedge clk);

    issue(1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",  int'(busy),  0, 0);
    chk("abort_done",  int'(done),  0, 0);
    chk("abort_c_pos", int'(c_pos), 0, 0);
    chk("abort_s_pos", int'(s_pos), 0, 0);
    chk("abort_c_neg", int'(c_neg), 0, 0);
    chk("abort_s_neg", int'(s_neg), 0, 0);
    chk("abort_quad",  int'(quad),  0, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * LAT) @(negedge clk);

    issue(5);
    wait_done("latency_after_reset", LAT);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
